// File: rtl/riscv_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// riscv_fetch_ctrl
//
// Fetch sequencer. Owns the program counter, issues one instruction-memory
// request at a time, tolerates a wait-stated memory, drops responses that a
// redirect has made stale, and holds each fetched instruction until decode
// accepts it.
//
// Ports:
//   clk, x_reset         clock, asynchronous active-low reset
//   redirect_valid       execute requests a PC change this cycle
//   redirect_sel         redirect source (pc_sel_e)
//   alu_out              JALR target
//   br_target, br_flag   branch target and taken flag
//   mtvec_addr           trap vector for ECALL
//   imem_req/imem_addr   request to instruction memory (addr stable until ack)
//   imem_ack/imem_rdata  single-cycle completion with instruction data
//   inst_valid/inst_out/inst_pc/inst_ready  held instruction to decode
//   discard_count        saturating count of discarded responses
// ---------------------------------------------------------------------------
package riscv_fetch_pkg;
  typedef enum logic [1:0] {
    PC_PLUS4        = 2'd0,
    PC_ALU          = 2'd1,
    PC_B_TARGET     = 2'd2,
    PC_ECALL_TARGET = 2'd3
  } pc_sel_e;
endpackage

module riscv_fetch_ctrl
  import riscv_fetch_pkg::*;
#(
  parameter int unsigned                WORD_LENGTH  = 32,
  parameter logic [WORD_LENGTH-1:0]     PC_OFFSET    = 4,
  parameter logic [WORD_LENGTH-1:0]     RESET_VECTOR = '0,
  parameter int unsigned                CNT_WIDTH    = 16
) (
  input  logic                   clk,
  input  logic                   x_reset,
  input  logic                   redirect_valid,
  input  pc_sel_e                redirect_sel,
  input  logic [WORD_LENGTH-1:0] alu_out,
  input  logic [WORD_LENGTH-1:0] br_target,
  input  logic                   br_flag,
  input  logic [WORD_LENGTH-1:0] mtvec_addr,
  output logic                   imem_req,
  output logic [WORD_LENGTH-1:0] imem_addr,
  input  logic                   imem_ack,
  input  logic [WORD_LENGTH-1:0] imem_rdata,
  output logic                   inst_valid,
  output logic [WORD_LENGTH-1:0] inst_out,
  output logic [WORD_LENGTH-1:0] inst_pc,
  input  logic                   inst_ready,
  output logic [CNT_WIDTH-1:0]   discard_count
);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN, HOLD} state_e;

  state_e                 state, state_d;
  logic [WORD_LENGTH-1:0] fetch_pc, fetch_pc_d;
  logic [WORD_LENGTH-1:0] req_addr, req_addr_d;
  logic                   take;
  logic [WORD_LENGTH-1:0] target;
  logic                   capture;
  logic                   discard;

  // Redirect decode. A not-taken branch or any non-redirect select is no take.
  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    take   = 1'b0;
    target = '0;
    case (redirect_sel)
      PC_ALU:          begin take = redirect_valid;           target = alu_out;    end
      PC_B_TARGET:     begin take = redirect_valid && br_flag; target = br_target;  end
      PC_ECALL_TARGET: begin take = redirect_valid;           target = mtvec_addr; end
      default:         ;
    endcase
  end

  // Next-state and datapath-update decode.
  always_comb begin
    state_d    = state;
    fetch_pc_d = fetch_pc;
    req_addr_d = req_addr;
    capture    = 1'b0;
    discard    = 1'b0;
    case (state)
      IDLE: begin
        state_d    = REQ;
        req_addr_d = take ? target : fetch_pc;
        if (take) fetch_pc_d = target;
      end
      REQ: begin
        if (imem_ack && take) begin
          // Response belongs to the old path; restart at the target at once.
          discard    = 1'b1;
          fetch_pc_d = target;
          req_addr_d = target;
        end else if (imem_ack) begin
          capture    = 1'b1;
          fetch_pc_d = req_addr + PC_OFFSET;
          state_d    = HOLD;
        end else if (take) begin
          // The outstanding request cannot be withdrawn; wait out its ack.
          fetch_pc_d = target;
          state_d    = DRAIN;
        end
      end
      DRAIN: begin
        if (take) fetch_pc_d = target;
        if (imem_ack) begin
          discard    = 1'b1;
          req_addr_d = take ? target : fetch_pc;
          state_d    = REQ;
        end
      end
      HOLD: begin
        // A take flushes decode, so it wins over a same-cycle inst_ready.
        if (take) begin
          fetch_pc_d = target;
          req_addr_d = target;
          state_d    = REQ;
        end else if (inst_ready) begin
          req_addr_d = fetch_pc;
          state_d    = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge x_reset) begin
    if (!x_reset) begin
      state         <= IDLE;
      fetch_pc      <= RESET_VECTOR;
      req_addr      <= RESET_VECTOR;
      inst_pc       <= RESET_VECTOR;
      inst_out      <= '0;
      discard_count <= '0;
    end else begin
      state    <= state_d;
      fetch_pc <= fetch_pc_d;
      req_addr <= req_addr_d;
      if (capture) begin
        inst_out <= imem_rdata;
        inst_pc  <= req_addr;
      end
      if (discard && (discard_count != '1)) discard_count <= discard_count + 1'b1;
    end
  end

  // Interface outputs decode straight from registers.
  assign imem_req   = (state == REQ) || (state == DRAIN);
  assign imem_addr  = req_addr;
  assign inst_valid = (state == HOLD);

endmodule
